// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin share of the register-file write port with a registered write stage
// and a per-register pending-write scoreboard for RAW hazard checks.
module reg_write_arbiter #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*IDX_W-1:0]  req_index,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        gnt,
    output logic [IDX_W-1:0]       write_index,
    output logic                   write_enable,
    output logic [DATA_W-1:0]      write_data,
    input  logic                   busy_set,
    input  logic [IDX_W-1:0]       busy_set_index,
    input  logic [IDX_W-1:0]       busy_index_rs,
    input  logic [IDX_W-1:0]       busy_index_rt,
    output logic                   busy_rs,
    output logic                   busy_rt
);
    localparam int pw = $clog2(NREQ);
    localparam logic [pw:0] nreq_w = (pw+1)'(NREQ);
    localparam int nreg = 1 << IDX_W;

    logic [pw-1:0]     ptr;
    logic [pw-1:0]     gnt_idx;
    logic [pw:0]       cand;
    logic              found;
    logic              grant;
    logic [IDX_W-1:0]  sel_index;
    logic [DATA_W-1:0] sel_data;
    logic [nreg-1:0]   busy;
    logic [nreg-1:0]   busy_nxt;

    // Search p, p+1, ... with an extra bit so the modulo wrap is exact for non-power-of-two NREQ.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (pw+1)'(k);
            cand = (cand >= nreq_w) ? cand - nreq_w : cand;
            if (!found && req[cand[pw-1:0]]) begin
                found   = 1'b1;
                gnt_idx = cand[pw-1:0];
            end
        end
    end

    assign grant     = found && reset;
    assign gnt       = grant ? NREQ'(1) << gnt_idx : '0;
    assign sel_index = req_index[gnt_idx*IDX_W +: IDX_W];
    assign sel_data  = req_data[gnt_idx*DATA_W +: DATA_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr          <= '0;
            write_enable <= 1'b0;
            write_index  <= '0;
            write_data   <= '0;
        end else begin
            write_enable <= grant && sel_index != '0;
            if (grant) begin
                ptr         <= (gnt_idx == pw'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
                write_index <= sel_index;
                write_data  <= sel_data;
            end
        end
    end

    // Set is applied after clear so a newer pending write on the same register survives.
    always_comb begin
        busy_nxt = busy;
        if (write_enable)
            busy_nxt[write_index] = 1'b0;
        if (busy_set && busy_set_index != '0)
            busy_nxt[busy_set_index] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    assign busy_rs = busy[busy_index_rs];
    assign busy_rt = busy[busy_index_rt];
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed checks of arbitration order, write latency, index-0 suppression,
// scoreboard set/clear priority and asynchronous reset.
module tb_reg_write_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [14:0] req_index;
    logic [95:0] req_data;
    logic [2:0]  gnt;
    logic [4:0]  write_index;
    logic        write_enable;
    logic [31:0] write_data;
    logic        busy_set;
    logic [4:0]  busy_set_index;
    logic [4:0]  busy_index_rs;
    logic [4:0]  busy_index_rt;
    logic        busy_rs;
    logic        busy_rt;
    int          n_cmp = 0;
    int          n_err = 0;

    reg_write_arbiter #(.NREQ(3), .DATA_W(32), .IDX_W(5)) dut (
        .clk(clk), .reset(reset), .req(req), .req_index(req_index), .req_data(req_data),
        .gnt(gnt), .write_index(write_index), .write_enable(write_enable), .write_data(write_data),
        .busy_set(busy_set), .busy_set_index(busy_set_index),
        .busy_index_rs(busy_index_rs), .busy_index_rt(busy_index_rt),
        .busy_rs(busy_rs), .busy_rt(busy_rt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [4:0] idx, input logic [31:0] data);
        req_index[i*5 +: 5]  = idx;
        req_data[i*32 +: 32] = data;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        req = 3'b111;
        req_index = '0;
        req_data = '0;
        busy_set = 1'b0;
        busy_set_index = '0;
        busy_index_rs = 5'd8;
        busy_index_rt = 5'd9;
        set_src(0, 5'd8, 32'hA);
        set_src(1, 5'd9, 32'hB);
        set_src(2, 5'd10, 32'hC);
        #2;
        chk("rst_gnt", gnt, 3'b000);
        chk("rst_we", write_enable, 1'b0);
        chk("rst_widx", write_index, 5'd0);
        chk("rst_wdata", write_data, 32'd0);
        chk("rst_busy_rs", busy_rs, 1'b0);
        chk("rst_busy_rt", busy_rt, 1'b0);
        tick;
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("rr_gnt%0d", c), gnt, 3'b001 << (c % 3));
            tick;
            chk($sformatf("rr_we%0d", c), write_enable, 1'b1);
            chk($sformatf("rr_widx%0d", c), write_index, 5'(8 + c % 3));
            chk($sformatf("rr_wdata%0d", c), write_data, 32'(10 + c % 3));
        end
        req = 3'b000;
        #1;
        chk("idle_gnt", gnt, 3'b000);
        tick;
        chk("idle_we", write_enable, 1'b0);
        chk("idle_widx_hold", write_index, 5'd10);
        chk("idle_wdata_hold", write_data, 32'hC);
        req = 3'b010;
        set_src(1, 5'd17, 32'hDEADBEEF);
        #1;
        chk("single_gnt", gnt, 3'b010);
        tick;
        req = 3'b000;
        chk("single_we", write_enable, 1'b1);
        chk("single_widx", write_index, 5'd17);
        chk("single_wdata", write_data, 32'hDEADBEEF);
        tick;
        chk("single_we_off", write_enable, 1'b0);
        chk("single_widx_hold", write_index, 5'd17);
        req = 3'b001;
        set_src(0, 5'd0, 32'h1234);
        #1;
        chk("zero_gnt", gnt, 3'b001);
        tick;
        req = 3'b000;
        chk("zero_we", write_enable, 1'b0);
        busy_set = 1'b1;
        busy_set_index = 5'd0;
        busy_index_rs = 5'd0;
        tick;
        busy_set = 1'b0;
        chk("zero_busy", busy_rs, 1'b0);
        busy_set = 1'b1;
        busy_set_index = 5'd5;
        busy_index_rs = 5'd5;
        busy_index_rt = 5'd6;
        #1;
        chk("sb_pre_set", busy_rs, 1'b0);
        tick;
        busy_set = 1'b0;
        chk("sb_set_rs", busy_rs, 1'b1);
        chk("sb_set_rt", busy_rt, 1'b0);
        req = 3'b100;
        set_src(2, 5'd5, 32'h55);
        #1;
        chk("sb_gnt", gnt, 3'b100);
        tick;
        req = 3'b000;
        chk("sb_wait_busy", busy_rs, 1'b1);
        chk("sb_we", write_enable, 1'b1);
        chk("sb_widx", write_index, 5'd5);
        tick;
        chk("sb_cleared", busy_rs, 1'b0);
        busy_set = 1'b1;
        tick;
        busy_set = 1'b0;
        chk("sb_reset_rs", busy_rs, 1'b1);
        req = 3'b100;
        #1;
        chk("sb2_gnt", gnt, 3'b100);
        tick;
        req = 3'b000;
        chk("sb2_we", write_enable, 1'b1);
        busy_set = 1'b1;
        tick;
        busy_set = 1'b0;
        chk("sb2_set_wins", busy_rs, 1'b1);
        tick;
        chk("sb2_still_busy", busy_rs, 1'b1);
        req = 3'b001;
        set_src(0, 5'd12, 32'h12);
        #1;
        chk("wd_pre_gnt", gnt, 3'b001);
        tick;
        chk("wd_pre_widx", write_index, 5'd12);
        req = 3'b101;
        set_src(0, 5'd3, 32'h33);
        set_src(2, 5'd7, 32'h77);
        #1;
        chk("wd_gnt_both", gnt, 3'b100);
        req = 3'b100;
        #1;
        chk("wd_gnt_after", gnt, 3'b100);
        tick;
        req = 3'b000;
        chk("wd_we", write_enable, 1'b1);
        chk("wd_widx", write_index, 5'd7);
        chk("wd_wdata", write_data, 32'h77);
        tick;
        chk("wd_we_off", write_enable, 1'b0);
        chk("wd_widx_hold", write_index, 5'd7);
        req = 3'b011;
        #1;
        chk("wd_ptr0", gnt, 3'b001);
        req = 3'b000;
        busy_set = 1'b1;
        busy_set_index = 5'd9;
        tick;
        busy_set = 1'b0;
        busy_index_rs = 5'd9;
        busy_index_rt = 5'd5;
        chk("mr_busy9", busy_rs, 1'b1);
        req = 3'b111;
        set_src(0, 5'd8, 32'hA);
        set_src(1, 5'd9, 32'hB);
        set_src(2, 5'd10, 32'hC);
        #1;
        chk("mr_gnt", gnt, 3'b001);
        tick;
        reset = 1'b0;
        #1;
        chk("mr_gnt_rst", gnt, 3'b000);
        chk("mr_we_rst", write_enable, 1'b0);
        chk("mr_wdata_rst", write_data, 32'd0);
        for (int i = 0; i < 32; i++) begin
            busy_index_rs = 5'(i);
            busy_index_rt = 5'(31 - i);
            #1;
            chk($sformatf("mr_busy_rs%0d", i), busy_rs, 1'b0);
            chk($sformatf("mr_busy_rt%0d", i), busy_rt, 1'b0);
        end
        tick;
        chk("mr_gnt_hold", gnt, 3'b000);
        chk("mr_we_hold", write_enable, 1'b0);
        reset = 1'b1;
        #1;
        chk("mr_first_gnt", gnt, 3'b001);
        tick;
        chk("mr_first_we", write_enable, 1'b1);
        chk("mr_first_widx", write_index, 5'd8);
        req = 3'b000;
        tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
